// File: rtl/zacore_prefetch.sv
// zacore_prefetch: instruction prefetch queue between memory and decode.
// Fetches words sequentially from fetch_pc into a circular FIFO and presents
// the oldest entry to decode. A redirect flushes the queue and restarts
// fetching at the new address. Reset takes priority over redirect.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   o_fetch_req         memory request (combinational: not full, no flush)
//   i_fetch_ack         memory accepts; i_inst_read valid in the same cycle
//   o_fetch_addr        word-aligned request address (equals fetch_pc)
//   i_inst_read         returned instruction word
//   o_valid/i_ready     head handshake towards decode
//   o_inst/o_pc         head instruction and its byte address
//   i_redirect(_pc)     flush and restart fetch at i_redirect_pc & ~3
//   o_count             queue occupancy
module zacore_prefetch #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  output logic                               o_fetch_req,
  input  logic                               i_fetch_ack,
  output logic [31:0]                        o_fetch_addr,
  input  logic [31:0]                        i_inst_read,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [31:0]                        o_inst,
  output logic [31:0]                        o_pc,
  input  logic                               i_redirect,
  input  logic [31:0]                        i_redirect_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t             mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        fetch_pc;
  logic               push;
  logic               pop;

  // Low address bits of the redirect target are discarded by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  // Request never looks at i_ready, so decode has no path to memory.
  assign o_fetch_req  = ~i_rst & ~i_redirect & (count < DEPTH_C);
  assign o_fetch_addr = fetch_pc;
  assign o_valid      = (count != '0);
  assign o_inst       = mem[rd_ptr].inst;
  assign o_pc         = mem[rd_ptr].pc;
  assign o_count      = count;

  assign push = o_fetch_req & i_fetch_ack;
  assign pop  = o_valid & i_ready & ~i_redirect & ~i_rst;

  // Queue storage: written on push only, never reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{inst: i_inst_read, pc: fetch_pc};
    end
  end

  // Pointers, occupancy and fetch address; reset beats redirect beats push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
    end else if (i_redirect) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= {i_redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_zacore_prefetch.sv
module tb_zacore_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_ack, ready, redirect;
  logic [31:0] redirect_pc;
  logic        fetch_req, valid;
  logic [31:0] fetch_addr, inst_read, inst, pc;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  // Memory image: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign inst_read = mem_word(fetch_addr);

  zacore_prefetch #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst(rst), .o_fetch_req(fetch_req), .i_fetch_ack(fetch_ack),
    .o_fetch_addr(fetch_addr), .i_inst_read(inst_read), .o_valid(valid),
    .i_ready(ready), .o_inst(inst), .o_pc(pc), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs are already driven (just after negedge). Check outputs
  // against the queue model, advance the model, then move to the next negedge.
  task automatic step();
    logic exp_req;
    logic do_push, do_pop;
    #1;
    exp_req = !rst && !redirect && (q.size() < DEPTH);
    chk("fetch_req", 32'(fetch_req), 32'(exp_req));
    if (!rst) chk("fetch_addr", fetch_addr, m_pc);
    chk("count", 32'(count), 32'(q.size()));
    chk("valid", 32'(valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_pc", pc, q[0].pc);
      chk("head_inst", inst, q[0].inst);
    end
    if (rst) begin
      q.delete();
      m_pc = RPC & ~32'd3;
    end else if (redirect) begin
      q.delete();
      m_pc = redirect_pc & ~32'd3;
    end else begin
      do_push = exp_req && fetch_ack;
      do_pop  = (q.size() != 0) && ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{inst: mem_word(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic a, input logic rd,
                       input logic rdr, input logic [31:0] rpc);
    rst = r; fetch_ack = a; ready = rd; redirect = rdr; redirect_pc = rpc;
  endtask

  initial begin
    q.delete();
    m_pc = 32'hDEAD_BEEF;
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    repeat (2) step();

    // Fill from reset with no decode: 0x0..0xC, then request drops.
    drive(0, 1, 0, 0, 0);
    repeat (6) step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_head_pc", pc, 32'h0);

    // Streaming: one push and one pop per cycle.
    drive(0, 1, 1, 0, 0);
    repeat (8) step();

    // Ack toggling with decode consuming.
    for (int i = 0; i < 10; i++) begin
      drive(0, (i % 2 == 0), 1, 0, 0);
      step();
    end

    // Redirect with three entries queued.
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0); repeat (3) step();
    chk("pre_redirect_count", 32'(count), 32'd3);
    drive(0, 1, 0, 1, 32'h0000_1002); step();
    chk("post_redirect_addr", fetch_addr, 32'h0000_1000);
    chk("post_redirect_valid", 32'(valid), 32'd0);
    drive(0, 1, 1, 0, 0); repeat (5) step();

    // Redirect near the top of the address space: fetch wraps to zero.
    drive(0, 1, 0, 1, 32'hFFFF_FFF8); step();
    drive(0, 1, 0, 0, 0); repeat (4) step();
    chk("wrap_head_pc", pc, 32'hFFFF_FFF8);
    drive(0, 1, 1, 0, 0); repeat (6) step();

    // Reset with redirect in the same cycle and two entries queued.
    drive(0, 1, 0, 1, 32'h0000_0400); step();
    drive(0, 1, 0, 0, 0); repeat (2) step();
    chk("pre_reset_count", 32'(count), 32'd2);
    drive(1, 1, 0, 1, 32'h0000_8000); step();
    chk("post_reset_addr", fetch_addr, RPC);
    chk("post_reset_count", 32'(count), 32'd0);
    drive(0, 0, 0, 0, 0); step();

    // Random traffic, including ready while empty and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0), $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
